// File: rtl/tero_resp_builder.sv
// rtl/tero_resp_builder.sv - TERO i/j count pair comparator and PUF response assembler
// Buffers the i-group counts, then compares each arriving j-count against the i-count at the same position.
module tero_resp_builder #(
   parameter int N_PAIRS = 80,
   parameter int CNT_W   = 16,
   parameter int IDX_W   = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               cnt_valid,
   input  logic [CNT_W-1:0]   cnt_in,
   output logic               cnt_ready,
   output logic               busy,
   output logic               resp_valid,
   output logic [N_PAIRS-1:0] resp_out,
   output logic [IDX_W-1:0]   tie_cnt
);

   localparam int AW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;

   typedef enum logic [1:0] {IDLE, FILL_I, CMP_J, DONE} state_t;

   state_t           state, state_next;
   logic [AW-1:0]    idx;
   logic [CNT_W-1:0] cnt_buf [N_PAIRS];
   logic [CNT_W-1:0] buf_rd;
   logic             in_eval;
   logic             xfer;
   logic             last;

   assign in_eval = (state == FILL_I) || (state == CMP_J);
   // start has priority: a sample offered alongside it is dropped
   assign xfer    = cnt_valid && in_eval && !start;
   assign last    = (idx == AW'(N_PAIRS - 1));
   assign buf_rd  = cnt_buf[idx];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      cnt_ready  = 1'b0;
      busy       = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: ;
         FILL_I: begin
            cnt_ready = 1'b1;
            busy      = 1'b1;
            if (xfer && last) state_next = CMP_J;
         end
         CMP_J: begin
            cnt_ready = 1'b1;
            busy      = 1'b1;
            if (xfer && last) state_next = DONE;
         end
         DONE: resp_valid = 1'b1;
         default: state_next = IDLE;
      endcase
      if (start) state_next = FILL_I;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx      <= '0;
         resp_out <= '0;
         tie_cnt  <= '0;
      end else if (start) begin
         idx      <= '0;
         resp_out <= '0;
         tie_cnt  <= '0;
      end else if (xfer) begin
         idx <= last ? '0 : idx + AW'(1);
         if (state == CMP_J) begin
            // a tie leaves the bit at 0 and is counted instead
            resp_out[idx] <= (cnt_in > buf_rd);
            if (cnt_in == buf_rd) tie_cnt <= tie_cnt + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (xfer && (state == FILL_I)) cnt_buf[idx] <= cnt_in;
   end

endmodule

// File: tb/tb_tero_resp_builder.sv
// tb/tb_tero_resp_builder.sv - randomized self-checking bench for tero_resp_builder
// Expected responses come from a per-pair comparison model over the i/j count arrays.
module tb_tero_resp_builder;

   localparam int N  = 80;
   localparam int CW = 16;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          cnt_valid = 1'b0;
   logic [CW-1:0] cnt_in = '0;
   logic          cnt_ready;
   logic          busy;
   logic          resp_valid;
   logic [N-1:0]  resp_out;
   logic [IW-1:0] tie_cnt;

   int errors = 0;
   int checks = 0;

   logic [CW-1:0] ia [N];
   logic [CW-1:0] ja [N];
   logic [N-1:0]  exp_resp;
   int            exp_ties;

   tero_resp_builder #(.N_PAIRS(N), .CNT_W(CW), .IDX_W(IW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .cnt_valid  (cnt_valid),
      .cnt_in     (cnt_in),
      .cnt_ready  (cnt_ready),
      .busy       (busy),
      .resp_valid (resp_valid),
      .resp_out   (resp_out),
      .tie_cnt    (tie_cnt)
   );

   always #5 clk = ~clk;

   // reference: pair p contributes 1 when j beats i, a tie when equal
   function automatic void model(input int upto);
      exp_resp = '0;
      exp_ties = 0;
      for (int p = 0; p < upto; p++) begin
         if (ja[p] > ia[p])       exp_resp[p] = 1'b1;
         else if (ja[p] == ia[p]) exp_ties++;
      end
   endfunction

   task automatic send(input logic [CW-1:0] v, input int gap);
      repeat (gap) begin
         checks++;
         if (cnt_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_ready: ready=%b busy=%b want 1 1", cnt_ready, busy);
         end
         @(negedge clk);
      end
      checks++;
      if (cnt_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_ready: ready=%b want 1", cnt_ready);
      end
      cnt_valid = 1'b1;
      cnt_in    = v;
      @(negedge clk);
      cnt_valid = 1'b0;
      cnt_in    = CW'($urandom);
   endtask

   task automatic run_eval(input bit do_start, input int gmax);
      if (do_start) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      for (int p = 0; p < N; p++) send(ia[p], (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0);
      for (int p = 0; p < N - 1; p++) send(ja[p], (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0);
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL valid_early: resp_valid=%b want 0", resp_valid);
      end
      send(ja[N-1], 0);
      model(N);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({cnt_ready, busy, resp_valid} !== 3'b000 || resp_out !== '0 || tie_cnt !== '0) begin
         errors++;
         $display("FAIL reset_state: ready=%b busy=%b valid=%b resp=%h tie=%0d want all 0",
                  cnt_ready, busy, resp_valid, resp_out, tie_cnt);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      for (int p = 0; p < N; p++) begin
         ia[p] = CW'(100 + p);
         ja[p] = (p % 2 == 0) ? CW'(200) : CW'(50);
      end
      run_eval(1'b1, 0);
      checks++;
      if (resp_out !== 80'h5555_5555_5555_5555_5555 || resp_out !== exp_resp) begin
         errors++;
         $display("FAIL basic_resp: got %h want %h", resp_out, exp_resp);
      end
      checks++;
      if (tie_cnt !== 8'd0 || resp_valid !== 1'b1 || busy !== 1'b0 || cnt_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: tie=%0d valid=%b busy=%b ready=%b want 0 1 0 0",
                  tie_cnt, resp_valid, busy, cnt_ready);
      end
   endtask

   task automatic test_ties();
      for (int p = 0; p < N; p++) begin
         ia[p] = 16'h1234;
         ja[p] = (p < 10) ? 16'h1234 : 16'h1235;
      end
      run_eval(1'b1, 0);
      checks++;
      if (resp_out !== exp_resp || resp_out[9:0] !== 10'd0) begin
         errors++;
         $display("FAIL ties_resp: got %h want %h", resp_out, exp_resp);
      end
      checks++;
      if (tie_cnt !== IW'(exp_ties) || tie_cnt !== 8'd10) begin
         errors++;
         $display("FAIL ties_cnt: got %0d want %0d", tie_cnt, exp_ties);
      end
   endtask

   task automatic test_gaps();
      for (int p = 0; p < N; p++) begin
         ia[p] = CW'(100 + p);
         ja[p] = (p % 2 == 0) ? CW'(200) : CW'(50);
      end
      run_eval(1'b1, 5);
      checks++;
      if (resp_out !== exp_resp || tie_cnt !== IW'(exp_ties)) begin
         errors++;
         $display("FAIL gaps_resp: got %h/%0d want %h/%0d", resp_out, tie_cnt, exp_resp, exp_ties);
      end
      checks++;
      if (busy !== 1'b0 || resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL gaps_done: busy=%b valid=%b want 0 1", busy, resp_valid);
      end
   endtask

   task automatic test_boundary();
      logic [N-1:0] held;
      for (int p = 0; p < N; p++) begin ia[p] = 16'hFFFF; ja[p] = 16'h0000; end
      run_eval(1'b1, 0);
      checks++;
      if (resp_out !== exp_resp || resp_out !== '0 || tie_cnt !== 8'd0) begin
         errors++;
         $display("FAIL bound_zero: got %h/%0d want %h/0", resp_out, tie_cnt, exp_resp);
      end
      for (int p = 0; p < N; p++) begin ia[p] = 16'h0000; ja[p] = 16'hFFFF; end
      run_eval(1'b1, 0);
      checks++;
      if (resp_out !== exp_resp || resp_out !== {N{1'b1}}) begin
         errors++;
         $display("FAIL bound_ones: got %h want %h", resp_out, exp_resp);
      end
      held = exp_resp;
      for (int k = 0; k < 6; k++) begin
         cnt_valid = 1'b1;
         cnt_in    = CW'($urandom);
         @(negedge clk);
         checks++;
         if (resp_out !== held || resp_valid !== 1'b1 || busy !== 1'b0 || cnt_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_ignore: resp=%h valid=%b busy=%b ready=%b want %h 1 0 0",
                     resp_out, resp_valid, busy, cnt_ready, held);
         end
      end
      cnt_valid = 1'b0;
   endtask

   task automatic randomize_data();
      for (int p = 0; p < N; p++) begin
         ia[p] = CW'($urandom);
         ja[p] = ($urandom_range(2, 0) == 0) ? ia[p] : CW'($urandom);
      end
   endtask

   task automatic test_abort();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int p = 0; p < 30; p++) send(CW'($urandom), 0);
      randomize_data();
      start     = 1'b1;
      cnt_valid = 1'b1;
      cnt_in    = ~ia[0];
      @(negedge clk);
      start     = 1'b0;
      cnt_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || resp_valid !== 1'b0 || tie_cnt !== 8'd0 || resp_out !== '0) begin
         errors++;
         $display("FAIL abort_clear: busy=%b valid=%b tie=%0d resp=%h want 1 0 0 0",
                  busy, resp_valid, tie_cnt, resp_out);
      end
      run_eval(1'b0, 2);
      checks++;
      if (resp_out !== exp_resp || tie_cnt !== IW'(exp_ties)) begin
         errors++;
         $display("FAIL abort_resp: got %h/%0d want %h/%0d", resp_out, tie_cnt, exp_resp, exp_ties);
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 3; r++) begin
         randomize_data();
         run_eval(1'b1, (r == 0) ? 0 : 3);
         checks++;
         if (resp_out !== exp_resp || tie_cnt !== IW'(exp_ties) || resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_resp run %0d: got %h/%0d v=%b want %h/%0d v=1",
                     r, resp_out, tie_cnt, resp_valid, exp_resp, exp_ties);
         end
      end
   endtask

   task automatic test_async_reset();
      randomize_data();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int p = 0; p < N; p++) send(ia[p], 0);
      for (int p = 0; p < 20; p++) send(ja[p], 0);
      model(20);
      checks++;
      if (resp_out !== exp_resp || tie_cnt !== IW'(exp_ties)) begin
         errors++;
         $display("FAIL partial_resp: got %h/%0d want %h/%0d", resp_out, tie_cnt, exp_resp, exp_ties);
      end
      cnt_valid = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({cnt_ready, busy, resp_valid} !== 3'b000 || resp_out !== '0 || tie_cnt !== '0) begin
         errors++;
         $display("FAIL async_reset: ready=%b busy=%b valid=%b resp=%h tie=%0d want all 0",
                  cnt_ready, busy, resp_valid, resp_out, tie_cnt);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cnt_in = CW'($urandom);
         @(negedge clk);
         checks++;
         if ({cnt_ready, busy, resp_valid} !== 3'b000 || resp_out !== '0 || tie_cnt !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: ready=%b busy=%b valid=%b resp=%h tie=%0d want all 0",
                     cnt_ready, busy, resp_valid, resp_out, tie_cnt);
         end
      end
      cnt_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ties();
      test_gaps();
      test_boundary();
      test_abort();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
